regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - Source 0 is the primary ALU/load writeback.
  - Source 1 is the secondary multi-cycle unit writeback (mult/div).
- Fixed priority to source 0, with a wait counter that guarantees source 1 a slot after MAX_WAIT consecutive losses.
- Drives a registered one-hot write-enable vector, data and address straight into the per-register enable/DataInput pins of the register file.

Parameters:
- DATA_W, 32, width of the write data.
- ADDR_W, 5, width of the register address.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.
- MAX_WAIT, 4, consecutive cycles source 1 may be denied before a forced grant; range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- freeze  input  1  pipeline freeze; no acceptance while high.
- req0_valid  input  1  source 0 write request.
- req0_addr  input  ADDR_W  source 0 destination register.
- req0_data  input  DATA_W  source 0 write data.
- req0_ready  output  1  source 0 accepted this cycle (combinational).
- req1_valid  input  1  source 1 write request.
- req1_addr  input  ADDR_W  source 1 destination register.
- req1_data  input  DATA_W  source 1 write data.
- req1_ready  output  1  source 1 accepted this cycle (combinational).
- wr_enable_vec  output  NUM_REGS  registered one-hot enable, bit i drives register i.
- wr_data  output  DATA_W  registered write data, common to all registers.
- wr_addr  output  ADDR_W  registered address of the last accepted write (debug/forwarding).
- wr_src  output  1  registered id of the source owning the current write slot.
- force_active  output  1  high while the anti-starvation override is granting source 1.

Behaviour:
- Reset: clk domain, reset asynchronous, active-low.
  - While reset=0: wr_enable_vec=0, wr_data=0, wr_addr=0, wr_src=0, force_active=0, wait_cnt=0, req0_ready=0, req1_ready=0.
  - Reset mid-operation drops any write in the output stage; no partial enable pulse is produced.
- Handshake: a request is accepted in cycle T when reqN_valid=1 and reqN_ready=1.
  - reqN_ready depends only on current inputs and state; it never depends on reqN_ready.
  - At most one ready is high per cycle.
  - A source must hold valid/addr/data stable until accepted.
- Grant rule (combinational, with freeze=0):
  - force = req1_valid & (wait_cnt == MAX_WAIT).
  - If force: grant source 1.
  - Else if req0_valid: grant source 0.
  - Else if req1_valid: grant source 1.
  - Else: no grant.
- freeze=1: both readys are 0 and wait_cnt holds its value. The output stage is cleared to wr_enable_vec=0 on the next edge; data and addr hold.
- wait_cnt update:
  - Increments (saturating at MAX_WAIT) when req1_valid=1 and source 1 is not granted.
  - Clears to 0 when source 1 is accepted, or when req1_valid=0.
- force_active = (wait_cnt == MAX_WAIT) & req1_valid & ~freeze.
- Output stage latency:
  - On the edge ending accept cycle T, wr_enable_vec becomes the decoded one-hot of the accepted address, and wr_data/wr_addr/wr_src are loaded.
  - During T+1 the enable is high; the register captures on the edge ending T+1.
  - Write completes 2 edges after request accept begins. Throughput is one write per cycle.
- No accept in a cycle: wr_enable_vec=0 on the next edge; wr_data/wr_addr/wr_src hold.
- Address 0: the request is accepted normally (ready=1, wr_addr=0), but wr_enable_vec stays all-zero. Register 0 is never written.
- Addresses ≥ NUM_REGS cannot occur by construction (NUM_REGS = 2**ADDR_W).
- Simultaneous valid with equal addresses: only the granted source writes; the loser retries in a later cycle and overwrites.

Decomposition:
- Shared package (regfile_pkg):
  - DATA_W, ADDR_W, NUM_REGS constants.
  - SRC_PRIMARY=0, SRC_SECONDARY=1 grant-id constants.
  - ZERO_REG=0.
- One sub-module: regfile_wr_decoder. Combinational ADDR_W→NUM_REGS one-hot decoder with enable input and zero-register suppression; reused by any future second write port.
- Grant logic, wait counter and output register stay in the top block.

Test Plan:
- Single write: req0 addr=5, data=32'hDEADBEEF, one cycle.
  -> req0_ready=1 same cycle; next cycle wr_enable_vec=32'h0000_0020, wr_data=32'hDEADBEEF, wr_src=0; following cycle wr_enable_vec=0.
- Contention: both valid, req0 addr=3, req1 addr=7.
  -> req0 accepted; req1 accepted the first cycle req0_valid drops; wr_enable_vec shows 32'h8 then 32'h80.
- Starvation (MAX_WAIT=4): req0_valid held high for 10 cycles, req1_valid high throughout.
  -> req1_ready=1 and force_active=1 exactly in the 5th cycle; wait_cnt returns to 0; req0 resumes winning.
- Zero register: req0 addr=0, data=32'h1234.
  -> req0_ready=1, wr_addr=0, wr_enable_vec stays 0 every cycle.
- Freeze: freeze=1 for 3 cycles with req0 and req1 valid.
  -> both readys 0, wr_enable_vec 0, wait_cnt unchanged; after release, normal grant order resumes.
- Reset mid-operation: assert reset=0 in the cycle after an accept (wr_enable_vec nonzero).
  -> wr_enable_vec, wr_data and wait_cnt read 0 immediately, without a clock edge; no write after release until a new accept.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write path.
// Both the arbiter and the one-hot write decoder import this package.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int WAIT_W   = 4;
   localparam int MAX_WAIT = 4;

   localparam logic SRC_PRIMARY   = 1'b0;
   localparam logic SRC_SECONDARY = 1'b1;

   localparam int ZERO_REG = 0;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_SRC0 = 2'd1,
      GRANT_SRC1 = 2'd2
   } grant_e;

endpackage

// File: rtl/regfile_wr_decoder.sv
// Address to one-hot register enable decoder with an enable input.
// The hardwired zero register never receives an enable bit.
module regfile_wr_decoder #(
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
   input  logic [ADDR_W-1:0]   addr,
   input  logic                enable,
   output logic [NUM_REGS-1:0] onehot
);

   import regfile_pkg::*;

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (enable && (addr == ADDR_W'(i)) && (i != ZERO_REG)) begin
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the primary
// writeback (source 0) and the multi-cycle unit (source 1) with starvation guard.
module regfile_write_arbiter #(
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS,
   parameter int MAX_WAIT = regfile_pkg::MAX_WAIT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                freeze,
   input  logic                req0_valid,
   input  logic [ADDR_W-1:0]   req0_addr,
   input  logic [DATA_W-1:0]   req0_data,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [ADDR_W-1:0]   req1_addr,
   input  logic [DATA_W-1:0]   req1_data,
   output logic                req1_ready,
   output logic [NUM_REGS-1:0] wr_enable_vec,
   output logic [DATA_W-1:0]   wr_data,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic                wr_src,
   output logic                force_active
);

   import regfile_pkg::*;

   logic [WAIT_W-1:0]   wait_cnt;
   logic [WAIT_W-1:0]   wait_cnt_next;
   grant_e              grant;
   logic                force_hit;
   logic                accept;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic                sel_src;
   logic [NUM_REGS-1:0] dec_vec;

   // Source 1 is forced through once it has lost MAX_WAIT cycles in a row.
   always_comb begin
      force_hit = req1_valid && (wait_cnt == WAIT_W'(MAX_WAIT));
      grant     = GRANT_NONE;
      if (reset && !freeze) begin
         if (force_hit) begin
            grant = GRANT_SRC1;
         end else if (req0_valid) begin
            grant = GRANT_SRC0;
         end else if (req1_valid) begin
            grant = GRANT_SRC1;
         end
      end
   end

   assign req0_ready   = (grant == GRANT_SRC0);
   assign req1_ready   = (grant == GRANT_SRC1);
   assign accept       = req0_ready || req1_ready;
   assign force_active = force_hit && !freeze && reset;

   always_comb begin
      sel_addr = req0_addr;
      sel_data = req0_data;
      sel_src  = SRC_PRIMARY;
      if (grant == GRANT_SRC1) begin
         sel_addr = req1_addr;
         sel_data = req1_data;
         sel_src  = SRC_SECONDARY;
      end
   end

   // Freeze holds the loss count so a stall never counts against source 1.
   always_comb begin
      wait_cnt_next = wait_cnt;
      if (!freeze) begin
         if (!req1_valid || (grant == GRANT_SRC1)) begin
            wait_cnt_next = '0;
         end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_next = wait_cnt + WAIT_W'(1);
         end
      end
   end

   regfile_wr_decoder #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_decoder (
      .addr   (sel_addr),
      .enable (accept),
      .onehot (dec_vec)
   );

   // The enable vector is a single-cycle pulse; data, addr and src persist.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt      <= '0;
         wr_enable_vec <= '0;
         wr_data       <= '0;
         wr_addr       <= '0;
         wr_src        <= SRC_PRIMARY;
      end else begin
         wait_cnt      <= wait_cnt_next;
         wr_enable_vec <= dec_vec;
         if (accept) begin
            wr_data <= sel_data;
            wr_addr <= sel_addr;
            wr_src  <= sel_src;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference model predicts grants
// and the next-cycle write, a monitor compares the registered outputs.
module tb_regfile_write_arbiter;

   localparam int MAX_WAIT = 4;

   typedef struct {
      logic [31:0] vec;
      logic [31:0] data;
      logic [4:0]  addr;
      logic        src;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        freeze;
   logic        req0_valid;
   logic [4:0]  req0_addr;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [4:0]  req1_addr;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic [31:0] wr_enable_vec;
   logic [31:0] wr_data;
   logic [4:0]  wr_addr;
   logic        wr_src;
   logic        force_active;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   int          m_losses;
   logic [31:0] m_data;
   logic [4:0]  m_addr;
   logic        m_src;
   logic        acc0;
   logic        acc1;

   regfile_write_arbiter #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NUM_REGS (32),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .freeze        (freeze),
      .req0_valid    (req0_valid),
      .req0_addr     (req0_addr),
      .req0_data     (req0_data),
      .req0_ready    (req0_ready),
      .req1_valid    (req1_valid),
      .req1_addr     (req1_addr),
      .req1_data     (req1_data),
      .req1_ready    (req1_ready),
      .wr_enable_vec (wr_enable_vec),
      .wr_data       (wr_data),
      .wr_addr       (wr_addr),
      .wr_src        (wr_src),
      .force_active  (force_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: grant from the priority rules, write appears one cycle later.
   always @(negedge clk) begin
      exp_t e;
      logic g0, g1, frc;
      logic [4:0] a;
      if (!reset) begin
         checkOutput("rst_ready0", {31'd0, req0_ready}, 32'd0);
         checkOutput("rst_ready1", {31'd0, req1_ready}, 32'd0);
         checkOutput("rst_vec", wr_enable_vec, 32'd0);
         checkOutput("rst_data", wr_data, 32'd0);
         checkOutput("rst_addr", {27'd0, wr_addr}, 32'd0);
         checkOutput("rst_src", {31'd0, wr_src}, 32'd0);
         checkOutput("rst_force", {31'd0, force_active}, 32'd0);
         m_losses = 0;
         m_data   = '0;
         m_addr   = '0;
         m_src    = 1'b0;
         acc0     = 1'b0;
         acc1     = 1'b0;
         e.vec = '0; e.data = '0; e.addr = '0; e.src = 1'b0;
         sb.push_back(e);
      end else begin
         frc = req1_valid && (m_losses >= MAX_WAIT);
         g0  = 1'b0;
         g1  = 1'b0;
         if (!freeze) begin
            if (frc)             g1 = 1'b1;
            else if (req0_valid) g0 = 1'b1;
            else if (req1_valid) g1 = 1'b1;
         end
         checkOutput("ready0", {31'd0, req0_ready}, {31'd0, g0});
         checkOutput("ready1", {31'd0, req1_ready}, {31'd0, g1});
         checkOutput("force_active", {31'd0, force_active}, {31'd0, frc && !freeze});
         if (!freeze) begin
            if (req1_valid && !g1) m_losses = (m_losses < MAX_WAIT) ? m_losses + 1 : MAX_WAIT;
            else                   m_losses = 0;
         end
         e.vec = '0;
         if (g0 || g1) begin
            a      = g0 ? req0_addr : req1_addr;
            m_addr = a;
            m_data = g0 ? req0_data : req1_data;
            m_src  = g1;
            if (a != 5'd0) e.vec = 32'd1 << a;
         end
         e.data = m_data; e.addr = m_addr; e.src = m_src;
         sb.push_back(e);
         acc0 = g0;
         acc1 = g1;
      end
   end

   // Monitor: compares registered outputs shortly after each edge.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("wr_enable_vec", wr_enable_vec, e.vec);
         checkOutput("wr_data", wr_data, e.data);
         checkOutput("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
         checkOutput("wr_src", {31'd0, wr_src}, {31'd0, e.src});
      end
   end

   task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic frz);
      @(posedge clk);
      #1;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      freeze     = frz;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      freeze = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      idle(2);

      $display("[TB] single write");
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
      idle(2);

      $display("[TB] contention");
      applyStimulus(1'b1, 5'd3, 32'h0000_0003, 1'b1, 5'd7, 32'h0000_0007, 1'b0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0007, 1'b0);
      idle(2);

      $display("[TB] starvation");
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 5'd2, 32'hA5A5_0002, 1'b1, 5'd9, 32'h5A5A_0009, 1'b0);
      idle(2);

      $display("[TB] zero register");
      applyStimulus(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b0);
      idle(2);

      $display("[TB] freeze");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd6, 32'h6666_6666, 1'b1);
      applyStimulus(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd6, 32'h6666_6666, 1'b0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h6666_6666, 1'b0);
      idle(2);

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 5'd5, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, 1'b0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8888_8888, 1'b0);
      @(posedge clk);
      #3 reset = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      checkOutput("async_rst_vec", wr_enable_vec, 32'd0);
      checkOutput("async_rst_data", wr_data, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      idle(3);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         logic v0, v1, frz;
         logic [4:0] a0, a1;
         logic [31:0] d0, d1;
         v0 = req0_valid; a0 = req0_addr; d0 = req0_data;
         v1 = req1_valid; a1 = req1_addr; d1 = req1_data;
         if (!v0 || acc0) begin
            v0 = ($urandom_range(0, 3) != 0);
            a0 = 5'($urandom_range(0, 31));
            d0 = $urandom;
         end
         if (!v1 || acc1) begin
            v1 = ($urandom_range(0, 1) != 0);
            a1 = 5'($urandom_range(0, 31));
            d1 = $urandom;
         end
         frz = ($urandom_range(0, 9) == 0);
         applyStimulus(v0, a0, d0, v1, a1, d1, frz);
      end
      idle(3);

      @(posedge clk);
      #4;
      checkOutput("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
